// File: rtl/contador_pkg.sv
// Shared constants and types for the up/down/load counter and its checker.
package contador_pkg;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  localparam int DOWN3_STEP = 3;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_CHECK  = 1'b1
  } chk_st_t;

  function automatic logic is_load(
    input logic       enb,
    input logic [1:0] modo
  );
    return enb && (modo == MODO_LOAD);
  endfunction

endpackage

// File: rtl/contador_checker_if.sv
// Counter stimulus/observation bundle: ENB/MODO/D driven to the counter,
// Q/RCO produced by it. The checker consumes every signal.
interface contador_checker_if #(
  parameter int WIDTH = 4
);
  logic             ENB;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             RCO;

  modport master (
    output ENB, MODO, D, Q, RCO
  );

  modport slave (
    input ENB, MODO, D, Q, RCO
  );
endinterface

// File: rtl/contador_next.sv
// Combinational next-state rule of the 4-mode counter (hold/up/down/down3/load).
module contador_next
  import contador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             rco_i,
  input  logic             enb_i,
  input  logic [1:0]       modo_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rco_o
);

  localparam logic [WIDTH-1:0] ONE  =
    WIDTH'(1);
  localparam logic [WIDTH-1:0] DEC3 =
    WIDTH'(DOWN3_STEP);

  always_comb begin
    q_o   = q_i;
    rco_o = rco_i;
    unique case (1'b1)
      !enb_i: begin
        q_o   = q_i;
        rco_o = rco_i;
      end
      enb_i && (modo_i == MODO_UP): begin
        q_o   = q_i + ONE;
        rco_o = &q_i;
      end
      enb_i && (modo_i == MODO_DOWN): begin
        q_o   = q_i - ONE;
        rco_o = 1'b0;
      end
      enb_i && (modo_i == MODO_DOWN3): begin
        q_o   = q_i - DEC3;
        rco_o = 1'b0;
      end
      enb_i && (modo_i == MODO_LOAD): begin
        q_o   = d_i;
        rco_o = 1'b1;
      end
      default: begin
        q_o   = q_i;
        rco_o = rco_i;
      end
    endcase
  end

endmodule

// File: rtl/contador_checker.sv
// Transition checker for the 4-mode counter; predicts Q one edge ahead.
// Define CONTADOR_CHK_RCO_EN to also check RCO against a predicted value.
module contador_checker
  import contador_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_L,
  contador_checker_if.slave    cnt,
  output logic                 SYNC,
  output logic                 ERR,
  output logic                 ERR_STICKY,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [WIDTH-1:0]     EXP_Q,
  output logic [WIDTH-1:0]     FIRST_EXP,
  output logic [WIDTH-1:0]     FIRST_OBS
);

  chk_st_t              st_q;
  logic                 sync_q;
  logic                 err_q;
  logic                 sticky_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]     exp_q_q;
  logic [WIDTH-1:0]     fexp_q;
  logic [WIDTH-1:0]     fobs_q;

  logic [WIDTH-1:0]     q_nx;
  logic                 rco_nx;
  logic                 q_bad;
  logic                 rco_bad;
  logic                 bad;
  logic                 load;

  contador_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q_i    (cnt.Q),
    .rco_i  (cnt.RCO),
    .enb_i  (cnt.ENB),
    .modo_i (cnt.MODO),
    .d_i    (cnt.D),
    .q_o    (q_nx),
    .rco_o  (rco_nx)
  );

  assign load  = is_load(cnt.ENB, cnt.MODO);
  // X/Z on Q must count as a mismatch in simulation
  assign q_bad = (cnt.Q !== exp_q_q);

`ifdef CONTADOR_CHK_RCO_EN
  logic exp_rco_q;

  assign rco_bad = (cnt.RCO !== exp_rco_q);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      exp_rco_q <= 1'b0;
    end else if (st_q == ST_CHECK || load) begin
      exp_rco_q <= rco_nx;
    end
  end
`else
  logic unused_rco;

  assign unused_rco = rco_nx;
  assign rco_bad    = 1'b0;
`endif

  assign bad = q_bad || rco_bad;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      st_q     <= ST_UNSYNC;
      sync_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      exp_q_q  <= '0;
      fexp_q   <= '0;
      fobs_q   <= '0;
    end else begin
      unique case (st_q)
        ST_UNSYNC: begin
          err_q <= 1'b0;
          if (load) begin
            st_q    <= ST_CHECK;
            sync_q  <= 1'b1;
            exp_q_q <= q_nx;
          end
        end
        ST_CHECK: begin
          err_q   <= bad;
          exp_q_q <= q_nx;
          if (bad) begin
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (!sticky_q) begin
              sticky_q <= 1'b1;
              fexp_q   <= exp_q_q;
              fobs_q   <= cnt.Q;
            end
          end
        end
        default: begin
          st_q <= ST_UNSYNC;
        end
      endcase
    end
  end

  assign SYNC       = sync_q;
  assign ERR        = err_q;
  assign ERR_STICKY = sticky_q;
  assign ERR_CNT    = cnt_q;
  assign EXP_Q      = exp_q_q;
  assign FIRST_EXP  = fexp_q;
  assign FIRST_OBS  = fobs_q;

endmodule

// File: tb/tb_contador_checker.sv
// Randomized bench for contador_checker against a behavioural checker model.
module tb_contador_checker;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  contador_checker_if #(.WIDTH(W)) bus ();

  logic          sync, err, sticky;
  logic [CW-1:0] err_cnt;
  logic [W-1:0]  exp_q, fexp, fobs;

  contador_checker #(
    .WIDTH     (W),
    .ERR_CNT_W (CW)
  ) dut (
    .CLK        (clk),
    .RESET_L    (rst_n),
    .cnt        (bus),
    .SYNC       (sync),
    .ERR        (err),
    .ERR_STICKY (sticky),
    .ERR_CNT    (err_cnt),
    .EXP_Q      (exp_q),
    .FIRST_EXP  (fexp),
    .FIRST_OBS  (fobs)
  );

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  bit         m_sync, m_err, m_sticky;
  int         m_cnt;
  logic [3:0] m_exp, m_fe, m_fo;
  logic       m_erco;

  logic [3:0] cq;
  logic       crco;

  function automatic logic [3:0] nq(input logic [3:0] q,
                                    input logic e,
                                    input logic [1:0] m,
                                    input logic [3:0] d);
    int v;
    v = int'(q);
    if (!e) return q;
    case (m)
      2'd0:    return 4'((v + 1) % 16);
      2'd1:    return 4'((v + 15) % 16);
      2'd2:    return 4'((v + 13) % 16);
      default: return d;
    endcase
  endfunction

  function automatic logic nr(input logic [3:0] q,
                              input logic r,
                              input logic e,
                              input logic [1:0] m);
    if (!e) return r;
    if (m == 2'd0) return (q == 4'd15);
    if (m == 2'd3) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_err = 0; m_sticky = 0;
    m_cnt = 0; m_exp = 0; m_fe = 0;
    m_fo = 0; m_erco = 0;
  endtask

  task automatic model_step(input logic e,
                            input logic [1:0] m,
                            input logic [3:0] d,
                            input logic [3:0] q,
                            input logic r);
    bit bad;
    if (!m_sync) begin
      m_err = 0;
      if (e && m == 2'd3) begin
        m_sync = 1; m_exp = d; m_erco = 1;
      end
    end else begin
      bad = (q !== m_exp);
`ifdef CONTADOR_CHK_RCO_EN
      bad = bad || (r !== m_erco);
`endif
      m_err = bad;
      if (bad) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!m_sticky) begin
          m_sticky = 1; m_fe = m_exp; m_fo = q;
        end
      end
      m_exp  = nq(q, e, m, d);
      m_erco = nr(q, r, e, m);
    end
  endtask

  task automatic check_all(input string p);
    chk({p, ".sync"}, sync, m_sync);
    chk({p, ".err"}, err, m_err);
    chk({p, ".cnt"}, err_cnt, m_cnt);
    chk({p, ".sticky"}, sticky, m_sticky);
    chk({p, ".fexp"}, fexp, m_fe);
    chk({p, ".fobs"}, fobs, m_fo);
    if (m_sync) chk({p, ".exp"}, exp_q, m_exp);
  endtask

  task automatic cyc(input logic e,
                     input logic [1:0] m,
                     input logic [3:0] d,
                     input string p);
    bus.ENB = e; bus.MODO = m; bus.D = d;
    bus.Q = cq; bus.RCO = crco;
    @(posedge clk);
    model_step(e, m, d, cq, crco);
    crco = nr(cq, crco, e, m);
    cq   = nq(cq, e, m, d);
    @(negedge clk);
    check_all(p);
  endtask

  task automatic chk_zero(input string p);
    chk({p, ".sync0"}, sync, 0);
    chk({p, ".err0"}, err, 0);
    chk({p, ".sticky0"}, sticky, 0);
    chk({p, ".cnt0"}, err_cnt, 0);
    chk({p, ".exp0"}, exp_q, 0);
    chk({p, ".fexp0"}, fexp, 0);
    chk({p, ".fobs0"}, fobs, 0);
  endtask

  initial begin
    model_reset();
    cq = 'x; crco = 'x;
    bus.ENB = 0; bus.MODO = 0; bus.D = 0;
    bus.Q = cq; bus.RCO = crco;
    #3 chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) cyc(1, 2'd0, 4'h0, "nold");

    cyc(1, 2'd3, 4'hE, "ldE");
    chk("ldE.q", exp_q, 4'hE);
    cyc(1, 2'd0, 4'h0, "up1");
    chk("up1.q", exp_q, 4'hF);
    cyc(1, 2'd0, 4'h0, "up2");
    chk("up2.q", exp_q, 4'h0);
    cyc(1, 2'd0, 4'h0, "up3");
    chk("up3.q", exp_q, 4'h1);

    cyc(1, 2'd3, 4'h1, "ld1");
    cyc(1, 2'd2, 4'h0, "dn3a");
    chk("dn3a.q", exp_q, 4'hE);
    cyc(1, 2'd2, 4'h0, "dn3b");
    chk("dn3b.q", exp_q, 4'hB);
    cq = 4'hC;
    cyc(1, 2'd1, 4'h0, "bad");
    chk("bad.err", err, 1);
    chk("bad.fexp", fexp, 4'hB);
    chk("bad.fobs", fobs, 4'hC);
    chk("bad.cnt", err_cnt, 1);
    chk("bad.q", exp_q, 4'hB);
    cyc(1, 2'd1, 4'h0, "nocas");
    chk("nocas.err", err, 0);
    chk("nocas.fexp", fexp, 4'hB);

    cyc(1, 2'd3, 4'h7, "ld7");
    repeat (5) cyc(0, 2'd0, 4'h0, "hold");
    chk("hold.cnt", err_cnt, 1);
    cq = 4'h8;
    cyc(0, 2'd2, 4'h3, "hbad");
    chk("hbad.err", err, 1);
    chk("hbad.cnt", err_cnt, 2);

    repeat (300) begin
      logic [3:0] dd;
      dd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0)
        cq = cq ^ 4'($urandom_range(1, 15));
      cyc($urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)), dd, "rnd");
    end

    repeat (300) begin
      cq = m_exp ^ 4'($urandom_range(1, 15));
      cyc(1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), "sat");
    end
    chk("sat.cnt", err_cnt, CMAX);
    chk("sat.err", err, 1);

    #2 rst_n = 1'b0;
    #1 chk_zero("mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(1, 2'd1, 4'h0, "unsync");
    chk("unsync.s", sync, 0);
    cyc(1, 2'd3, 4'h3, "reld");
    chk("reld.s", sync, 1);
    chk("reld.q", exp_q, 4'h3);
    repeat (40) cyc($urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), "tail");

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
